// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered 1-bit framebuffer.
//   swap_state_t : swap handshake FSM states
//   fb_lin_addr  : linear pixel address y*hor+x, also used by the renderer
package fb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } swap_state_t;

  function automatic int unsigned fb_lin_addr(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned hor);
    return y * hor + x;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port 1-bit RAM holding both framebuffer banks.
// Ports:
//   clk        : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : {bank, pixel address}, MSB selects the bank
//   i_wr_data  : write data
//   i_rd_addr  : {bank, pixel address}, MSB selects the bank
//   o_rd_data  : registered read data, one cycle after i_rd_addr
module fb_bank_ram #(
  parameter int unsigned DEPTH      = 307200,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   i_wr_addr,
  input  logic                  i_wr_data,
  input  logic [ADDR_WIDTH:0]   i_rd_addr,
  output logic                  o_rd_data
);

  // No reset on the array or read register so the RAM maps to block RAM.
  logic r_mem [2][DEPTH];
  logic r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr[ADDR_WIDTH]][i_wr_addr[ADDR_WIDTH-1:0]] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr[ADDR_WIDTH]][i_rd_addr[ADDR_WIDTH-1:0]];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 1-bit framebuffer between the renderer and video scan-out.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   ce                : renderer clock enable (only used to release swap)
//   wr_en/addr/data   : renderer pixel writes into the back bank
//   frame_end         : start of vertical blanking, exchanges banks
//   swap              : held high until the renderer's ce samples it
//   rd_en/rd_x/rd_y   : scan-out read request from the front bank
//   rd_valid/rd_data  : read response, two cycles after the request
//   front_bank        : current front bank index
module frame_buffer
  import fb_pkg::*;
#(
  parameter  int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter  int unsigned VER_ACTIVE_PIXELS = 480,
  localparam int unsigned FB_DEPTH          = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int unsigned WR_ADDR_WIDTH     = $clog2(FB_DEPTH),
  localparam int unsigned X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
  localparam int unsigned Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic                     wr_data,
  input  logic                     frame_end,
  output logic                     swap,
  input  logic                     rd_en,
  input  logic [X_WIDTH-1:0]       rd_x,
  input  logic [Y_WIDTH-1:0]       rd_y,
  output logic                     rd_valid,
  output logic                     rd_data,
  output logic                     front_bank
);

  swap_state_t r_state, w_state_next;
  logic        r_front, w_front_next;

  logic                     w_wr_in_range;
  logic                     w_rd_oob;
  logic [WR_ADDR_WIDTH-1:0] w_rd_lin;
  logic                     w_ram_q;

  logic                     r_s1_valid;
  logic                     r_s1_oob;
  logic                     r_s1_bank;
  logic [WR_ADDR_WIDTH-1:0] r_s1_addr;
  logic                     r_s2_valid;
  logic                     r_s2_oob;

  // Swap FSM and bank select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_front <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_front <= w_front_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_front_next = r_front;
    unique case (r_state)
      IDLE: begin
        if (frame_end) begin
          w_front_next = ~r_front;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        // A second frame_end before the renderer saw swap folds into one indication.
        if (frame_end) begin
          w_front_next = ~r_front;
        end else if (ce) begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  assign swap       = (r_state == HOLD);
  assign front_bank = r_front;

  // Write side: back bank is taken from the pre-toggle front bank.
  assign w_wr_in_range = 32'(wr_addr) < FB_DEPTH;

  // Read side: out-of-range coordinates are parked on address 0 so the RAM
  // index stays inside the bank; their data is forced to 0 on the way out.
  assign w_rd_oob = (32'(rd_x) >= HOR_ACTIVE_PIXELS) || (32'(rd_y) >= VER_ACTIVE_PIXELS);
  assign w_rd_lin = w_rd_oob ? '0 :
                    WR_ADDR_WIDTH'(fb_lin_addr(32'(rd_x), 32'(rd_y), HOR_ACTIVE_PIXELS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_oob   <= 1'b0;
      r_s1_bank  <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_oob   <= 1'b0;
    end else begin
      r_s1_valid <= rd_en;
      r_s1_oob   <= w_rd_oob;
      r_s1_bank  <= r_front;
      r_s1_addr  <= w_rd_lin;
      r_s2_valid <= r_s1_valid;
      r_s2_oob   <= r_s1_oob;
    end
  end

  fb_bank_ram #(
    .DEPTH      (FB_DEPTH),
    .ADDR_WIDTH (WR_ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (wr_en && w_wr_in_range),
    .i_wr_addr ({~r_front, wr_addr}),
    .i_wr_data (wr_data),
    .i_rd_addr ({r_s1_bank, r_s1_addr}),
    .o_rd_data (w_ram_q)
  );

  assign rd_valid = r_s2_valid;
  assign rd_data  = r_s2_valid & ~r_s2_oob & w_ram_q;

endmodule

// File: tb/tb_frame_buffer.sv
module tb_frame_buffer;

  localparam int HOR   = 20;
  localparam int VER   = 12;
  localparam int DEPTH = HOR * VER;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = $clog2(HOR);
  localparam int YW    = $clog2(VER);

  logic          clk = 1'b0;
  logic          rst, ce, wr_en, wr_data, frame_end, rd_en;
  logic [AW-1:0] wr_addr;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          swap, rd_valid, rd_data, front_bank;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_mem   [2][DEPTH];
  bit m_known [2][DEPTH];
  bit m_front, m_hold;
  bit p_valid, p_oob, p_bank;
  int p_addr;
  bit e_valid, e_data, e_known;

  always #5 clk = ~clk;

  frame_buffer #(
    .HOR_ACTIVE_PIXELS (HOR),
    .VER_ACTIVE_PIXELS (VER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_end  (frame_end),
    .swap       (swap),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .front_bank (front_bank)
  );

  task automatic model_reset();
    m_front = 1'b0;
    m_hold  = 1'b0;
    p_valid = 1'b0;
    e_valid = 1'b0;
    e_data  = 1'b0;
    e_known = 1'b1;
  endtask

  // One clock edge; the model advances by the rules: a read taken last edge
  // returns what its captured bank held before this edge, new requests take
  // the pre-toggle front bank, writes go to the pre-toggle back bank.
  task automatic tick();
    @(posedge clk);
    if (p_valid) begin
      e_valid = 1'b1;
      if (p_oob) begin
        e_data  = 1'b0;
        e_known = 1'b1;
      end else begin
        e_data  = m_mem[p_bank][p_addr];
        e_known = m_known[p_bank][p_addr];
      end
    end else begin
      e_valid = 1'b0;
      e_data  = 1'b0;
      e_known = 1'b1;
    end
    p_valid = rd_en;
    p_oob   = (int'(rd_x) >= HOR) || (int'(rd_y) >= VER);
    p_bank  = m_front;
    p_addr  = p_oob ? 0 : int'(rd_y) * HOR + int'(rd_x);
    if (wr_en && int'(wr_addr) < DEPTH) begin
      m_mem[~m_front][int'(wr_addr)]   = wr_data;
      m_known[~m_front][int'(wr_addr)] = 1'b1;
    end
    if (frame_end) begin
      m_front = ~m_front;
      m_hold  = 1'b1;
    end else if (m_hold && ce) begin
      m_hold = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
    frame_end = 1'b0; rd_en = 1'b0; rd_x = '0; rd_y = '0;
    #3;
    model_reset();
    n_vec++; if (swap !== 1'b0) begin n_err++; $display("FAIL reset_swap: got %b want 0", swap); end
    n_vec++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL reset_front: got %b want 0", front_bank); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_vec++; if (rd_data !== 1'b0) begin n_err++; $display("FAIL reset_rd_data: got %b want 0", rd_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    rd_en = 1'b1; rd_x = '0; rd_y = '0;
    tick();
    rd_en = 1'b0;
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL first_read_t1: got %b want 0", rd_valid); end
    tick();
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL first_read_t2: got %b want 1", rd_valid); end
    n_vec++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL first_read_front: got %b want 0", front_bank); end
    n_vec++; if (swap !== 1'b0) begin n_err++; $display("FAIL first_read_swap: got %b want 0", swap); end
  endtask

  task automatic test_swap_read();
    wr_en = 1'b1; wr_addr = AW'(6); wr_data = 1'b0;
    tick();
    wr_addr = AW'(5); wr_data = 1'b1;
    tick();
    wr_en = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_vec++; if (front_bank !== 1'b1) begin n_err++; $display("FAIL swap_front: got %b want 1", front_bank); end
    n_vec++; if (swap !== 1'b1) begin n_err++; $display("FAIL swap_raised: got %b want 1", swap); end
    ce = 1'b1; rd_en = 1'b1; rd_x = XW'(5); rd_y = '0;
    tick();
    rd_x = XW'(6);
    tick();
    rd_en = 1'b0; ce = 1'b0;
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b1) begin
      n_err++; $display("FAIL read_5_0: got v=%b d=%b want v=1 d=1", rd_valid, rd_data);
    end
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b0) begin
      n_err++; $display("FAIL read_6_0: got v=%b d=%b want v=1 d=0", rd_valid, rd_data);
    end
    tick();
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 1'b0) begin
      n_err++; $display("FAIL read_idle: got v=%b d=%b want v=0 d=0", rd_valid, rd_data);
    end
  endtask

  task automatic test_stretch();
    int hi;
    hi = 0;
    ce = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    if (swap === 1'b1) hi++;
    repeat (4) begin
      tick();
      if (swap === 1'b1) hi++;
    end
    ce = 1'b1;
    tick();
    ce = 1'b0;
    n_vec++; if (hi != 5) begin n_err++; $display("FAIL stretch_len: got %0d want 5", hi); end
    n_vec++; if (swap !== 1'b0) begin n_err++; $display("FAIL stretch_release: got %b want 0", swap); end
    n_vec++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL stretch_front: got %b want 0", front_bank); end
  endtask

  task automatic test_same_edge();
    wr_en = 1'b1; wr_addr = AW'(10); wr_data = 1'b0;
    tick();
    frame_end = 1'b1; wr_data = 1'b1;
    tick();
    frame_end = 1'b0; wr_en = 1'b0;
    rd_en = 1'b1; rd_x = XW'(10); rd_y = '0; ce = 1'b1;
    tick();
    rd_en = 1'b0; ce = 1'b0;
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b1) begin
      n_err++; $display("FAIL same_edge_write: got v=%b d=%b want v=1 d=1", rd_valid, rd_data);
    end
    n_vec++; if (front_bank !== 1'b1) begin n_err++; $display("FAIL same_edge_front: got %b want 1", front_bank); end
  endtask

  task automatic test_no_tearing();
    // bank1[10]=1 from before; make bank0[10]=0
    wr_en = 1'b1; wr_addr = AW'(10); wr_data = 1'b0;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_x = XW'(10); rd_y = '0;
    tick();
    rd_en = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b1) begin
      n_err++; $display("FAIL no_tearing: got v=%b d=%b want v=1 d=1", rd_valid, rd_data);
    end
    n_vec++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL no_tearing_front: got %b want 0", front_bank); end
    ce = 1'b1;
    tick();
    ce = 1'b0;
    // Read on the same edge as frame_end uses the pre-toggle front (bank0)
    rd_en = 1'b1; frame_end = 1'b1;
    tick();
    rd_en = 1'b0; frame_end = 1'b0;
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b0) begin
      n_err++; $display("FAIL read_with_frame_end: got v=%b d=%b want v=1 d=0", rd_valid, rd_data);
    end
    ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  task automatic test_bounds();
    wr_en = 1'b1; wr_data = 1'b1;
    wr_addr = AW'(0);     tick();
    wr_addr = AW'(20);    tick();
    wr_addr = AW'(DEPTH); tick();
    wr_addr = AW'(255);   tick();
    wr_en = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0; ce = 1'b1;
    rd_en = 1'b1; rd_x = XW'(HOR); rd_y = '0;
    tick();
    rd_x = '0; rd_y = YW'(VER);
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b0) begin
      n_err++; $display("FAIL x_out_of_range: got v=%b d=%b want v=1 d=0", rd_valid, rd_data);
    end
    rd_x = '0; rd_y = '0;
    tick();
    rd_en = 1'b0; ce = 1'b0;
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b0) begin
      n_err++; $display("FAIL y_out_of_range: got v=%b d=%b want v=1 d=0", rd_valid, rd_data);
    end
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 1'b1) begin
      n_err++; $display("FAIL in_range_0_0: got v=%b d=%b want v=1 d=1", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    // Fill both banks so every later read has a known expectation
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < DEPTH; a++) begin
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = 1'($urandom);
        tick();
      end
      wr_en = 1'b0; frame_end = 1'b1;
      tick();
      frame_end = 1'b0; ce = 1'b1;
      tick();
      ce = 1'b0;
    end
    for (int i = 0; i < 3000; i++) begin
      wr_en     = 1'($urandom);
      wr_addr   = AW'($urandom);
      wr_data   = 1'($urandom);
      rd_en     = 1'($urandom);
      rd_x      = XW'($urandom);
      rd_y      = YW'($urandom);
      ce        = 1'($urandom);
      frame_end = ($urandom_range(31, 0) == 0);
      tick();
      n_vec++; if (rd_valid !== e_valid) begin
        n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, rd_valid, e_valid);
      end
      if (e_known) begin
        n_vec++; if (rd_data !== e_data) begin
          n_err++; $display("FAIL rand_data[%0d]: got %b want %b", i, rd_data, e_data);
        end
      end
      n_vec++; if (front_bank !== m_front) begin
        n_err++; $display("FAIL rand_front[%0d]: got %b want %b", i, front_bank, m_front);
      end
      n_vec++; if (swap !== m_hold) begin
        n_err++; $display("FAIL rand_swap[%0d]: got %b want %b", i, swap, m_hold);
      end
    end
    wr_en = 1'b0; frame_end = 1'b0; rd_en = 1'b0; ce = 1'b1;
    tick();
    ce = 1'b0;
    // Scan both banks back-to-back against the model contents
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < DEPTH + 2; a++) begin
        rd_en = (a < DEPTH);
        rd_x  = XW'(a % HOR);
        rd_y  = YW'((a / HOR) % VER);
        tick();
        n_vec++; if (rd_valid !== e_valid) begin
          n_err++; $display("FAIL scan_valid[%0d/%0d]: got %b want %b", pass, a, rd_valid, e_valid);
        end
        n_vec++; if (rd_data !== e_data) begin
          n_err++; $display("FAIL scan_data[%0d/%0d]: got %b want %b", pass, a, rd_data, e_data);
        end
      end
      rd_en = 1'b0; frame_end = 1'b1;
      tick();
      frame_end = 1'b0; ce = 1'b1;
      tick();
      ce = 1'b0;
    end
  endtask

  task automatic test_reset_hold();
    ce = 1'b0; wr_en = 1'b0;
    rd_en = 1'b1; rd_x = XW'(3); rd_y = YW'(2); frame_end = 1'b1;
    tick();
    if (!m_front) tick();
    frame_end = 1'b0;
    tick();
    n_vec++; if (swap !== 1'b1 || front_bank !== 1'b1 || rd_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: got s=%b f=%b v=%b want s=1 f=1 v=1", swap, front_bank, rd_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_vec++; if (swap !== 1'b0) begin n_err++; $display("FAIL async_swap: got %b want 0", swap); end
    n_vec++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL async_front: got %b want 0", front_bank); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", rd_valid); end
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    tick();
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 1'b0) begin
      n_err++; $display("FAIL inflight_discard: got v=%b d=%b want v=0 d=0", rd_valid, rd_data);
    end
    n_vec++; if (swap !== 1'b0 || front_bank !== 1'b0) begin
      n_err++; $display("FAIL post_reset: got s=%b f=%b want s=0 f=0", swap, front_bank);
    end
  endtask

  initial begin
    test_reset();
    test_swap_read();
    test_stretch();
    test_same_edge();
    test_no_tearing();
    test_bounds();
    test_random();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered 1-bit framebuffer sitting directly downstream of the frame renderer.
- Accepts the renderer's pixel writes (wr_en/wr_addr/wr_data) into the back bank and serves pixel reads from the front bank to the video scan-out.
- On each end-of-frame pulse from video timing, exchanges the banks and issues the renderer's swap pulse, stretched until the renderer's clock enable samples it.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line.
- VER_ACTIVE_PIXELS, 480, visible lines per frame.
- FB_DEPTH (localparam), HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS, pixels per bank.
- WR_ADDR_WIDTH (localparam), $clog2(FB_DEPTH), write address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- ce  input  1  renderer clock enable; used only for swap stretching.
- wr_en  input  1  renderer write strobe.
- wr_addr  input  WR_ADDR_WIDTH  linear pixel address (y*HOR_ACTIVE_PIXELS+x).
- wr_data  input  1  pixel value.
- frame_end  input  1  one-cycle pulse from video timing at start of vertical blanking.
- swap  output  1  to renderer: back bank freshly released, start next frame.
- rd_en  input  1  scan-out read request.
- rd_x  input  $clog2(HOR_ACTIVE_PIXELS)  column.
- rd_y  input  $clog2(VER_ACTIVE_PIXELS)  line.
- rd_valid  output  1  rd_data valid.
- rd_data  output  1  pixel from front bank.
- front_bank  output  1  current front bank index (debug/verification).

Behaviour:
- Reset (rst low, asynchronous): front_bank=0, swap=0, rd_valid=0, rd_data=0, read pipeline cleared. Memory contents are not reset.
- Write bank = ~front_bank, sampled in the same cycle as wr_en.
- Write at edge t lands in that bank. A write with wr_addr >= FB_DEPTH is dropped silently.
- Writes are accepted every cycle. ce does not gate writes.
- Read pipeline, 2-cycle latency:
  - Cycle t: rd_en, rd_x, rd_y and front_bank are captured.
  - Cycle t+1: the linear address rd_y*HOR_ACTIVE_PIXELS+rd_x is registered and the RAM is read.
  - Cycle t+2: rd_valid=1 and rd_data is presented.
  - Fully pipelined: one read per cycle.
  - rd_x >= HOR_ACTIVE_PIXELS or rd_y >= VER_ACTIVE_PIXELS gives rd_valid=1, rd_data=0.
  - No rd_en gives rd_valid=0 and rd_data holds 0.
- The bank used by a read is the one captured at cycle t. A flip during t+1/t+2 does not alter in-flight reads (no tearing).
- Swap FSM states:
  - IDLE: frame_end → toggle front_bank, swap←1, go to HOLD.
  - HOLD: swap stays 1. At the first cycle with ce=1 while in HOLD (swap was already 1 at that edge), go to IDLE and clear swap. So swap is 1 for at least one cycle and is guaranteed seen by one ce cycle.
  - frame_end while in HOLD: toggle front_bank again, stay in HOLD, swap remains 1. This is a single swap indication; a missed frame is acceptable.
- Simultaneous frame_end and wr_en at the same edge: the write goes to the pre-toggle back bank, which becomes front at that edge.
- Simultaneous frame_end and rd_en: the read uses the pre-toggle front bank.
- Reset mid-frame: FSM returns to IDLE, swap drops immediately (asynchronous), and the in-flight read is discarded.

Decomposition:
- Shared package fb_pkg:
  - swap_state_t enum {IDLE, HOLD}.
  - Helper function for the linear-address calculation, shared with the renderer.
- Sub-module fb_bank_ram:
  - Simple dual-port 1-bit RAM, depth 2*FB_DEPTH.
  - Address MSB is the bank select.
  - Synchronous read with 1-cycle latency, no reset, inferable as block RAM.
- frame_buffer holds the swap FSM, bank select, address generation and the valid pipeline.

Test Plan:
- Reset, then rd_en at (0,0) → rd_valid=1 at t+2; front_bank=0, swap=0 throughout.
- Write wr_addr=5, wr_data=1 to bank 1; pulse frame_end; read (5,0) → front_bank=1, rd_data=1 at t+2; read (6,0) → 0.
- frame_end with ce held 0 for 4 cycles, then ce=1 → swap high 5 cycles, low the cycle after the ce cycle.
- Same-edge frame_end and wr_en (addr 10, data 1); read (10,0) next cycle → rd_data=1.
- rd_en at cycle t, frame_end at t+1 → rd_data at t+2 comes from the old bank.
- rd_x=HOR_ACTIVE_PIXELS → rd_valid=1, rd_data=0. wr_addr=FB_DEPTH → no bank modified (scoreboard check).
- Assert rst low mid-HOLD → swap=0 and front_bank=0 immediately.
